// File: rtl/sa_leaf_stage.sv
// Leaf stream stage: buffers upstream words in a small FIFO and stamps each one
// with the instance index and a wrapping sequence number.
module sa_leaf_stage #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int INST_ID = 0,
  parameter int SEQ_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [2:0]                 out_id,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [SEQ_W-1:0]  seqs_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;

  logic push, pop;

  // Handshake qualifiers depend only on registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = data_q[rd_ptr_q];
  assign out_seq  = seqs_q[rd_ptr_q];
  assign out_id   = 3'(INST_ID);
  assign count    = count_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    seq_ctr_d = seq_ctr_q;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      seq_ctr_d = seq_ctr_q + SEQ_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      seq_ctr_q <= '0;
      data_q    <= '{default: '0};
      seqs_q    <= '{default: '0};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      seq_ctr_q <= seq_ctr_d;
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        seqs_q[wr_ptr_q] <= seq_ctr_q;
      end
    end
  end

endmodule

// File: tb/tb_sa_leaf_stage.sv
// Directed self-checking bench for sa_leaf_stage (default parameters).
module tb_sa_leaf_stage;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int INST_ID = 0;
  localparam int SEQ_W   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_id;
  logic [SEQ_W-1:0]  out_seq;
  logic [CNT_W-1:0]  count;

  int compared   = 0;
  int mismatched = 0;

  sa_leaf_stage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .INST_ID(INST_ID),
    .SEQ_W  (SEQ_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_seq  (out_seq),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset check
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_seq",   32'(out_seq),   32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);

    // Single word, no bypass when empty
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    check("single_no_bypass", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_seq",   32'(out_seq),   32'd0);
    check("single_id",    32'(out_id),    32'(INST_ID));
    check("single_count", 32'(count),     32'd1);
    tick();
    check("single_drained", 32'(count),     32'd0);
    check("single_empty",   32'(out_valid), 32'd0);

    // Fill and backpressure
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
    end
    check("fill_count",    32'(count),    32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h05;
    tick();
    check("fill_reject_count", 32'(count),    32'd4);
    check("fill_hold_data",    32'(out_data), 32'h01);
    check("fill_hold_seq",     32'(out_seq),  32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_drain_valid", 32'(out_valid), 32'd1);
      check("fill_drain_data",  32'(out_data),  32'(i + 1));
      check("fill_drain_seq",   32'(out_seq),   32'(i));
      tick();
    end
    check("fill_drain_count", 32'(count), 32'd0);

    // Full plus pop: first cycle pops only, second pushes and pops
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      tick();
    end
    in_data   = 8'h20;
    out_ready = 1'b1;
    check("fp_full_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("fp_c1_count", 32'(count),    32'd3);
    check("fp_c1_head",  32'(out_data), 32'h11);
    check("fp_c1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("fp_c2_count", 32'(count),    32'd3);
    check("fp_c2_head",  32'(out_data), 32'h12);
    check("fp_c2_seq",   32'(out_seq),  32'd2);
    tick();
    check("fp_d_data13", 32'(out_data), 32'h13);
    check("fp_d_seq3",   32'(out_seq),  32'd3);
    tick();
    check("fp_d_data20", 32'(out_data), 32'h20);
    check("fp_d_seq4",   32'(out_seq),  32'd4);
    tick();
    check("fp_d_empty",  32'(count),    32'd0);

    // Sequence wrap over 17 streamed words
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(8'h30 + i);
      tick();
      check("wrap_seq",   32'(out_seq),  32'(i % 16));
      check("wrap_data",  32'(out_data), 32'(8'h30 + i));
      check("wrap_count", 32'(count),    32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("wrap_empty", 32'(count), 32'd0);

    // Mid-stream reset discards buffered words and handshakes
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      tick();
    end
    check("mr_pre_count", 32'(count), 32'd3);
    in_data   = 8'h99;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("mr_count", 32'(count),     32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_data",  32'(out_data),  32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    check("mr_next_seq",   32'(out_seq),  32'd0);
    check("mr_next_data",  32'(out_data), 32'h55);
    check("mr_next_count", 32'(count),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sa_leaf_stage.md
# sa_leaf_stage

Leaf-level stream stage instantiated beneath each `sa9_*` instance of the 200-module hierarchy. It sits directly downstream of its parent's instance slot and consumes the parent's word stream. Each accepted word is buffered in a small FIFO and stamped with the instance index and a wrapping sequence number. The stamped word is then presented on a valid/ready output toward the next consumer.

## Interface
- `DATA_W`, 8: payload width in bits.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `INST_ID`, 0: instance index, 0..4, matching the parent `inst_N`.
- `SEQ_W`, 4: sequence-number width in bits.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: stage can accept a word.
- `in_data` in DATA_W: upstream payload.
- `out_valid` out 1: head word is valid.
- `out_ready` in 1: downstream accepts the head word.
- `out_data` out DATA_W: head payload.
- `out_id` out 3: constant `INST_ID`.
- `out_seq` out SEQ_W: sequence number stamped on the head word.
- `count` out clog2(DEPTH+1): current occupancy.

## Operation
- Push: `in_valid && in_ready`. The word `{in_data, seq_ctr}` is written at `wr_ptr`, then `wr_ptr` and `count` advance.
- Pop: `out_valid && out_ready`. `rd_ptr` advances and `count` decrements.
- Simultaneous push and pop:
  - Both pointers advance and `count` is unchanged.
  - This is legal at any occupancy where both handshakes are individually permitted.
- Full (`count == DEPTH`): `in_ready = 0`, so no push occurs even if a pop happens in the same cycle. There is no combinational `out_ready`-to-`in_ready` path.
- Empty (`count == 0`): `out_valid = 0`. A push in this cycle is not visible at the output until the next cycle; there is no bypass.
- Sequence counter `seq_ctr`:
  - Increments by 1 only on a push.
  - Wraps from 2^SEQ_W−1 to 0.
  - Its value before the increment is the value stamped into the pushed word.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from `count`, not from pointer comparison.
- Output mapping: `out_data` and `out_seq` are the storage entry at `rd_ptr`. `out_id` is tied to `INST_ID`.
- The stage never drops or duplicates a word. Data order equals push order.

## Timing
- Reset (while `rst` = 1 at a clock edge):
  - `wr_ptr`, `rd_ptr`, `count` and `seq_ctr` are set to 0.
  - All storage entries are cleared to 0.
  - Outputs after reset: `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `out_seq` = 0, `count` = 0.
- Reset asserted mid-stream: all buffered words are discarded in that cycle. Handshakes in the reset cycle have no effect.
- Latency from push at edge N:
  - The word appears on `out_*` after edge N if the FIFO was empty.
  - Otherwise it appears once all earlier words have been popped.
- Throughput: one word per cycle sustained when `out_ready` is held at 1.
- `in_ready`, `out_valid` and `count` are functions of registered state only.
- Output stability: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_seq` hold their values.

## Test plan
- **Reset check.** Drive `rst` = 1 for 2 cycles, then release → `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_seq` = 0.
- **Single word.** Push `0xA5` with `out_ready` = 1 → next cycle `out_valid` = 1, `out_data` = `0xA5`, `out_seq` = 0, `out_id` = `INST_ID`. Following cycle `count` = 0.
- **Fill and backpressure.**
  - Push `0x01` to `0x04` with `out_ready` = 0 → `count` = 4 and `in_ready` = 0.
  - A fifth `in_valid` with `0x05` is not accepted.
  - Then set `out_ready` = 1 → output order is `0x01`..`0x04` with seq 0..3.
- **Full plus pop.** With `count` = 4, raise `out_ready` while `in_valid` = 1 → cycle 1: pop only, `count` = 3. Cycle 2: push and pop together, `count` = 3.
- **Sequence wrap.** Stream 17 words with `SEQ_W` = 4 → `out_seq` runs 0..15 then 0 on the 17th word.
- **Mid-stream reset.** With 3 words buffered, pulse `rst` for 1 cycle → `count` = 0 and `out_valid` = 0. The next push gets seq 0.
